// File: rtl/vec_issue_ctrl.sv
// Issue sequencer between the scalar-to-vector instruction FIFO and the vector dispatch decoder.
// Holds off issue while a multi-cycle multiply or a memory operation is outstanding.
module vec_issue_ctrl #(
    parameter int INSTRUCTION_BITS = 32,
    parameter int MUL_LATENCY      = 3,
    parameter int MEM_TIMEOUT      = 1024,
    parameter int CNT_BITS         = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fifo_valid,
    input  logic [INSTRUCTION_BITS-1:0] instr_in,
    output logic                        fifo_pop,
    output logic                        valid_instruction,
    input  logic                        ready_vector,
    input  logic                        memory_done,
    output logic                        busy,
    output logic                        mul_pending,
    output logic                        mem_pending,
    output logic                        mem_timeout_err,
    output logic [CNT_BITS-1:0]         issue_count,
    output logic [CNT_BITS-1:0]         stall_count
);

    localparam int MUL_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam int MEM_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [MUL_W-1:0]    mul_cnt_q, mul_cnt_d;
    logic [MEM_W-1:0]    mem_cnt_q, mem_cnt_d;
    logic                err_q, err_d;
    logic [CNT_BITS-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

    logic       issue;
    logic       is_mem;
    logic       is_mul;
    logic [6:0] opcode;
    logic [8:0] choice;
    logic       unused_instr;

    assign opcode       = instr_in[6:0];
    assign choice       = {instr_in[14:12], instr_in[31:26]};
    assign unused_instr = ^instr_in;

    always_comb begin
        is_mem = (opcode == 7'b0000111) || (opcode == 7'b0100111);
        is_mul = 1'b0;
        case (choice)
            9'b010100101, 9'b110100101, 9'b010100111, 9'b110100111,
            9'b010100100, 9'b110100100, 9'b010100110, 9'b110100110,
            9'b010101101, 9'b110101101, 9'b010101001, 9'b110101001: is_mul = 1'b1;
            default: is_mul = 1'b0;
        endcase
    end

    assign valid_instruction = fifo_valid && (state_q == IDLE);
    assign issue             = valid_instruction && ready_vector;
    assign fifo_pop          = issue;

    always_comb begin
        state_d     = state_q;
        mul_cnt_d   = mul_cnt_q;
        mem_cnt_d   = mem_cnt_q;
        err_d       = err_q;
        issue_cnt_d = issue_cnt_q + CNT_BITS'(issue);
        stall_cnt_d = stall_cnt_q + CNT_BITS'(fifo_valid && !issue);

        case (state_q)
            IDLE: begin
                if (issue) begin
                    // Memory classification takes priority over the multiply decode.
                    if (is_mem) begin
                        state_d   = MEM_WAIT;
                        mem_cnt_d = '0;
                    end else if (is_mul && (MUL_LATENCY > 1)) begin
                        state_d   = MUL_WAIT;
                        mul_cnt_d = MUL_W'(MUL_LATENCY - 1);
                    end
                end
            end
            MUL_WAIT: begin
                mul_cnt_d = mul_cnt_q - 1'b1;
                if (mul_cnt_q == MUL_W'(1)) begin
                    state_d = IDLE;
                end
            end
            MEM_WAIT: begin
                if (memory_done) begin
                    state_d = IDLE;
                end else if (mem_cnt_q == MEM_W'(MEM_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    mem_cnt_d = mem_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mul_cnt_q   <= '0;
            mem_cnt_q   <= '0;
            err_q       <= 1'b0;
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mul_cnt_q   <= mul_cnt_d;
            mem_cnt_q   <= mem_cnt_d;
            err_q       <= err_d;
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign mul_pending     = (state_q == MUL_WAIT);
    assign mem_pending     = (state_q == MEM_WAIT);
    assign mem_timeout_err = err_q;
    assign issue_count     = issue_cnt_q;
    assign stall_count     = stall_cnt_q;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Directed checks of vec_issue_ctrl issue gating, wait states, timeout flag and counters.
module tb_vec_issue_ctrl;

    localparam int IB = 32;
    localparam int CB = 16;

    localparam logic [31:0] I_ALU   = 32'h0000_0057;
    localparam logic [31:0] I_MUL   = 32'h9400_2057;
    localparam logic [31:0] I_LOAD  = 32'h0000_0007;
    localparam logic [31:0] I_STORE = 32'h0000_0027;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_valid;
    logic [IB-1:0] instr_in;
    logic          fifo_pop;
    logic          valid_instruction;
    logic          ready_vector;
    logic          memory_done;
    logic          busy;
    logic          mul_pending;
    logic          mem_pending;
    logic          mem_timeout_err;
    logic [CB-1:0] issue_count;
    logic [CB-1:0] stall_count;

    int n_checks = 0;
    int n_pass   = 0;

    vec_issue_ctrl #(
        .INSTRUCTION_BITS(IB),
        .MUL_LATENCY     (3),
        .MEM_TIMEOUT     (8),
        .CNT_BITS        (CB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_valid       (fifo_valid),
        .instr_in         (instr_in),
        .fifo_pop         (fifo_pop),
        .valid_instruction(valid_instruction),
        .ready_vector     (ready_vector),
        .memory_done      (memory_done),
        .busy             (busy),
        .mul_pending      (mul_pending),
        .mem_pending      (mem_pending),
        .mem_timeout_err  (mem_timeout_err),
        .issue_count      (issue_count),
        .stall_count      (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Advance one clock, then let inputs and combinational outputs settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; fifo_valid = 1'b0; ready_vector = 1'b1; memory_done = 1'b0; instr_in = I_ALU;
        tick();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        rst = 1'b1; fifo_valid = 1'b0; ready_vector = 1'b0; memory_done = 1'b0; instr_in = '0;
        tick(); tick();
        do_reset();
        $display("reset state");
        check("rst_busy", busy, 0);
        check("rst_err", mem_timeout_err, 0);
        check("rst_issue_cnt", issue_count, 0);
        check("rst_stall_cnt", stall_count, 0);
        check("rst_valid_instr", valid_instruction, 0);

        // Four back-to-back ALU ops
        $display("alu burst");
        fifo_valid = 1'b1; instr_in = I_ALU; settle();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("alu_pop%0d", i), fifo_pop, 1);
            tick();
        end
        fifo_valid = 1'b0; settle();
        check("alu_issue_cnt", issue_count, 4);
        check("alu_stall_cnt", stall_count, 0);
        check("alu_busy", busy, 0);

        // MUL then ALU: ALU pops 3 cycles after the MUL
        do_reset();
        $display("mul spacing");
        fifo_valid = 1'b1; instr_in = I_MUL; settle();
        check("mul_pop", fifo_pop, 1);
        tick();
        instr_in = I_ALU; settle();
        for (int i = 1; i <= 2; i++) begin
            check($sformatf("mul_wait_pop%0d", i), fifo_pop, 0);
            check($sformatf("mul_pending%0d", i), mul_pending, 1);
            tick();
        end
        check("mul_alu_pop", fifo_pop, 1);
        check("mul_pending_end", mul_pending, 0);
        tick();
        fifo_valid = 1'b0; settle();
        check("mul_stall_cnt", stall_count, 2);
        check("mul_issue_cnt", issue_count, 2);

        // LOAD, memory_done 5 cycles after issue, ALU queued behind it
        do_reset();
        $display("load with done");
        fifo_valid = 1'b1; instr_in = I_LOAD; settle();
        check("ld_pop", fifo_pop, 1);
        tick();
        instr_in = I_ALU;
        for (int i = 1; i <= 5; i++) begin
            memory_done = (i == 5);
            settle();
            check($sformatf("ld_pending%0d", i), mem_pending, 1);
            check($sformatf("ld_wait_pop%0d", i), fifo_pop, 0);
            tick();
        end
        memory_done = 1'b0; settle();
        check("ld_alu_pop", fifo_pop, 1);
        check("ld_pending_end", mem_pending, 0);
        tick();
        fifo_valid = 1'b0; settle();
        check("ld_stall_cnt", stall_count, 5);
        check("ld_err", mem_timeout_err, 0);

        // STORE without memory_done: timeout after 8 wait cycles
        do_reset();
        $display("store timeout");
        fifo_valid = 1'b1; instr_in = I_STORE; settle();
        check("st_pop", fifo_pop, 1);
        tick();
        fifo_valid = 1'b0; settle();
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("st_pending%0d", i), mem_pending, 1);
            check($sformatf("st_err_early%0d", i), mem_timeout_err, 0);
            tick();
        end
        check("st_pending_end", mem_pending, 0);
        check("st_err_set", mem_timeout_err, 1);
        fifo_valid = 1'b1; instr_in = I_ALU; settle();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("st_alu_pop%0d", i), fifo_pop, 1);
            tick();
            check($sformatf("st_err_sticky%0d", i), mem_timeout_err, 1);
        end
        fifo_valid = 1'b0; settle();
        check("st_issue_cnt", issue_count, 3);

        // Decoder back-pressure for 3 cycles
        do_reset();
        $display("backpressure");
        fifo_valid = 1'b1; ready_vector = 1'b0; instr_in = I_ALU; settle();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_valid%0d", i), valid_instruction, 1);
            check($sformatf("bp_pop%0d", i), fifo_pop, 0);
            tick();
        end
        ready_vector = 1'b1; settle();
        check("bp_pop_go", fifo_pop, 1);
        tick();
        fifo_valid = 1'b0; settle();
        check("bp_stall_cnt", stall_count, 3);
        check("bp_issue_cnt", issue_count, 1);

        // Reset during MEM_WAIT, then a late memory_done is ignored
        do_reset();
        $display("reset mid mem wait");
        fifo_valid = 1'b1; instr_in = I_LOAD; settle();
        tick();
        fifo_valid = 1'b0; settle();
        check("rm_pending", mem_pending, 1);
        rst = 1'b1; tick(); rst = 1'b0; settle();
        check("rm_busy", busy, 0);
        check("rm_issue_cnt", issue_count, 0);
        check("rm_err", mem_timeout_err, 0);
        memory_done = 1'b1; tick(); memory_done = 1'b0; settle();
        check("rm_late_done_busy", busy, 0);

        // Reset during MUL_WAIT
        $display("reset mid mul wait");
        fifo_valid = 1'b1; instr_in = I_MUL; settle();
        tick();
        fifo_valid = 1'b0; settle();
        check("rmul_pending", mul_pending, 1);
        rst = 1'b1; tick(); rst = 1'b0; settle();
        check("rmul_busy", busy, 0);
        check("rmul_issue_cnt", issue_count, 0);
        check("rmul_stall_cnt", stall_count, 0);
        memory_done = 1'b1; tick(); memory_done = 1'b0; settle();
        check("rmul_late_done_busy", busy, 0);
        fifo_valid = 1'b1; instr_in = I_ALU; settle();
        check("rmul_alu_pop", fifo_pop, 1);
        tick();
        fifo_valid = 1'b0; settle();
        check("rmul_issue_after", issue_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
